// File: rtl/pong_pkg.sv
// Shared Pong definitions: sequencer state encoding, default screen/paddle
// geometry and the derived-position helpers. The video pattern generator
// uses the same helpers, so the drawn geometry matches the game logic.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STEP,
    ST_HIT,
    ST_SCORE,
    ST_SERVE
  } pong_state_t;

  localparam int PONG_H_ACTIVE     = 640;
  localparam int PONG_V_ACTIVE     = 480;
  localparam int PONG_BALL         = 8;
  localparam int PONG_PAD_W        = 8;
  localparam int PONG_PAD_H        = 64;
  localparam int PONG_PAD_X        = 16;
  localparam int PONG_SPEED        = 4;
  localparam int PONG_MAX_SCORE    = 9;
  localparam int PONG_SERVE_FRAMES = 60;

  // Ball top-left X when centred horizontally.
  function automatic int pong_cx(input int h_active, input int ball);
    return (h_active - ball) / 2;
  endfunction

  // Ball top-left Y when centred vertically.
  function automatic int pong_cy(input int v_active, input int ball);
    return (v_active - ball) / 2;
  endfunction

  // Ball X at which its left edge touches the left paddle face.
  function automatic int pong_lface(input int pad_x, input int pad_w);
    return pad_x + pad_w;
  endfunction

  // Ball X at which its right edge touches the right paddle face.
  function automatic int pong_rface(input int h_active, input int pad_x,
                                    input int pad_w, input int ball);
    return h_active - pad_x - pad_w - ball;
  endfunction

endpackage

// File: rtl/pong_edge_tick.sv
// Frame tick generator: delays vs by one clock and flags its rising edge.
//   i_clk   pixel clock
//   i_reset synchronous active-high reset
//   i_vs    vertical sync from the video generator
//   o_tick  high for the single cycle where vs is 1 and was 0 last cycle
module pong_edge_tick (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_vs,
  output logic o_tick
);

  logic r_vs_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vs_d <= 1'b0;
    end else begin
      r_vs_d <= i_vs;
    end
  end

  assign o_tick = i_vs & ~r_vs_d;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer. Moves the ball once per video frame, bounces it off
// the top/bottom walls and the paddles, keeps score, holds the ball at the
// centre for a serve delay after each point and stops at game over.
//   clk          pixel clock
//   reset        synchronous active-high reset
//   vs           vertical sync; its rising edge is the frame tick
//   run          1 = play, 0 = pause
//   pongbar1_y   left paddle top Y
//   pongbar2_y   right paddle top Y
//   bal_x/bal_y  ball top-left position
//   score1/2     left/right player score
//   game_over    a player has reached MAX_SCORE
//   frame_update one-cycle pulse when a new ball position is presented
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int H_ACTIVE     = PONG_H_ACTIVE,
  parameter int V_ACTIVE     = PONG_V_ACTIVE,
  parameter int BALL         = PONG_BALL,
  parameter int PAD_W        = PONG_PAD_W,
  parameter int PAD_H        = PONG_PAD_H,
  parameter int PAD_X        = PONG_PAD_X,
  parameter int SPEED        = PONG_SPEED,
  parameter int MAX_SCORE    = PONG_MAX_SCORE,
  parameter int SERVE_FRAMES = PONG_SERVE_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vs,
  input  logic        run,
  input  logic [15:0] pongbar1_y,
  input  logic [15:0] pongbar2_y,
  output logic [15:0] bal_x,
  output logic [15:0] bal_y,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic        game_over,
  output logic        frame_update
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [16:0] CX17    = 17'(pong_cx(H_ACTIVE, BALL));
  localparam logic [16:0] CY17    = 17'(pong_cy(V_ACTIVE, BALL));
  localparam logic [16:0] LFACE17 = 17'(pong_lface(PAD_X, PAD_W));
  localparam logic [16:0] RFACE17 = 17'(pong_rface(H_ACTIVE, PAD_X, PAD_W, BALL));
  localparam logic [16:0] XMAX17  = 17'(H_ACTIVE - BALL);
  localparam logic [16:0] YMAX17  = 17'(V_ACTIVE - BALL);
  localparam logic [16:0] SPD17   = 17'(SPEED);
  localparam logic [16:0] BALL17  = 17'(BALL);
  localparam logic [16:0] PADH17  = 17'(PAD_H);
  localparam logic [15:0] PMAX16  = 16'(V_ACTIVE - PAD_H);
  localparam logic [3:0]  MAX4    = 4'(MAX_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_FRAMES);

  // Subtract one step, stopping at 0 instead of wrapping.
  function automatic logic [16:0] step_dec(input logic [16:0] v);
    return (v < SPD17) ? 17'd0 : v - SPD17;
  endfunction

  function automatic logic [16:0] clamp_hi(input logic [16:0] v,
                                           input logic [16:0] hi);
    return (v > hi) ? hi : v;
  endfunction

  // Keep a paddle fully on screen.
  function automatic logic [15:0] clamp_pad(input logic [15:0] p);
    return (p > PMAX16) ? PMAX16 : p;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= MAX4) ? MAX4 : s + 4'd1;
  endfunction

  pong_state_t      r_state;
  logic [15:0]      r_x, r_y, r_x_prev, r_pb1, r_pb2;
  logic             r_dir_x_right, r_dir_y_down;
  logic [3:0]       r_score1, r_score2;
  logic             r_game_over, r_frame_update;
  logic [CNT_W-1:0] r_serve_cnt;
  logic             r_left_scored;

  logic             w_tick;
  logic [16:0]      w_x17, w_y17, w_xp17, w_x_step, w_y_step;
  logic             w_flip_y;
  logic             w_ovl1, w_ovl2, w_hit_l, w_hit_r, w_miss_l, w_miss_r;
  logic             w_final;

  pong_edge_tick u_edge_tick (
    .i_clk   (clk),
    .i_reset (reset),
    .i_vs    (vs),
    .o_tick  (w_tick)
  );

  assign w_x17  = {1'b0, r_x};
  assign w_y17  = {1'b0, r_y};
  assign w_xp17 = {1'b0, r_x_prev};

  // ---- STEP: next position, X clamped to the screen, Y reflected at walls
  always_comb begin
    w_x_step = w_x17;
    w_y_step = w_y17;
    w_flip_y = 1'b0;
    if (r_dir_x_right) begin
      w_x_step = clamp_hi(w_x17 + SPD17, XMAX17);
    end else begin
      w_x_step = step_dec(w_x17);
    end
    if (r_dir_y_down) begin
      w_y_step = w_y17 + SPD17;
      if (w_y_step >= YMAX17) begin
        w_y_step = YMAX17;
        w_flip_y = 1'b1;
      end
    end else if (w_y17 <= SPD17) begin
      w_y_step = 17'd0;
      w_flip_y = 1'b1;
    end else begin
      w_y_step = w_y17 - SPD17;
    end
  end

  // ---- HIT: paddle overlap and face crossing on the stepped position.
  // A bounce needs the ball to cross the face during this frame, so a ball
  // already behind the paddle can only run on to the screen edge.
  assign w_ovl1 = (w_y17 + BALL17 > {1'b0, r_pb1}) && (w_y17 < {1'b0, r_pb1} + PADH17);
  assign w_ovl2 = (w_y17 + BALL17 > {1'b0, r_pb2}) && (w_y17 < {1'b0, r_pb2} + PADH17);

  assign w_hit_l  = ~r_dir_x_right && (w_xp17 > LFACE17) && (w_x17 <= LFACE17) && w_ovl1;
  assign w_hit_r  =  r_dir_x_right && (w_xp17 < RFACE17) && (w_x17 >= RFACE17) && w_ovl2;
  assign w_miss_l = ~r_dir_x_right && (w_x17 == 17'd0);
  assign w_miss_r =  r_dir_x_right && (w_x17 == XMAX17);

  // ---- SCORE: the score bumped in HIT decides whether the game is over
  assign w_final = r_left_scored ? (r_score1 == MAX4) : (r_score2 == MAX4);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_x            <= CX17[15:0];
      r_y            <= CY17[15:0];
      r_x_prev       <= CX17[15:0];
      r_pb1          <= '0;
      r_pb2          <= '0;
      r_dir_x_right  <= 1'b1;
      r_dir_y_down   <= 1'b1;
      r_score1       <= '0;
      r_score2       <= '0;
      r_game_over    <= 1'b0;
      r_frame_update <= 1'b0;
      r_serve_cnt    <= '0;
      r_left_scored  <= 1'b0;
    end else begin
      r_frame_update <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_x <= CX17[15:0];
          r_y <= CY17[15:0];
          if (run) begin
            // A finished game is cleared first; play starts a cycle later.
            if (r_game_over) begin
              r_score1    <= '0;
              r_score2    <= '0;
              r_game_over <= 1'b0;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_tick && run) begin
            r_pb1   <= clamp_pad(pongbar1_y);
            r_pb2   <= clamp_pad(pongbar2_y);
            r_state <= ST_STEP;
          end
        end
        ST_STEP: begin
          r_x_prev <= r_x;
          r_x      <= w_x_step[15:0];
          r_y      <= w_y_step[15:0];
          if (w_flip_y) begin
            r_dir_y_down <= ~r_dir_y_down;
          end
          r_state <= ST_HIT;
        end
        ST_HIT: begin
          if (w_hit_l) begin
            r_x            <= LFACE17[15:0];
            r_dir_x_right  <= 1'b1;
            r_frame_update <= 1'b1;
            r_state        <= ST_WAIT;
          end else if (w_hit_r) begin
            r_x            <= RFACE17[15:0];
            r_dir_x_right  <= 1'b0;
            r_frame_update <= 1'b1;
            r_state        <= ST_WAIT;
          end else if (w_miss_l) begin
            r_score2      <= sat_inc(r_score2);
            r_left_scored <= 1'b0;
            r_state       <= ST_SCORE;
          end else if (w_miss_r) begin
            r_score1      <= sat_inc(r_score1);
            r_left_scored <= 1'b1;
            r_state       <= ST_SCORE;
          end else begin
            r_frame_update <= 1'b1;
            r_state        <= ST_WAIT;
          end
        end
        ST_SCORE: begin
          r_x <= CX17[15:0];
          r_y <= CY17[15:0];
          if (w_final) begin
            r_game_over <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            // Serve toward the player who just conceded.
            r_dir_x_right  <= r_left_scored;
            r_serve_cnt    <= SERVE_LD;
            r_frame_update <= 1'b1;
            r_state        <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          r_x <= CX17[15:0];
          r_y <= CY17[15:0];
          // Serve delay counts frames even while paused.
          if (r_serve_cnt == '0) begin
            r_state <= ST_WAIT;
          end else if (w_tick) begin
            r_serve_cnt <= r_serve_cnt - 1'b1;
            if (r_serve_cnt == CNT_W'(1)) begin
              r_state <= ST_WAIT;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bal_x        = r_x;
  assign bal_y        = r_y;
  assign score1       = r_score1;
  assign score2       = r_score2;
  assign game_over    = r_game_over;
  assign frame_update = r_frame_update;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl. The ball path is driven from reset
// through wall bounces, both paddle bounces, a left miss with serve delay,
// nine right misses to game over, and a reset taken in the HIT state.
// Expected positions are hand-derived from the 4 px/frame motion.
module tb_pong_game_ctrl;

  logic        clk = 1'b0;
  logic        reset, vs, run;
  logic [15:0] pb1, pb2;
  logic [15:0] bal_x, bal_y;
  logic [3:0]  score1, score2;
  logic        game_over, frame_update;

  int n_checks = 0;
  int n_errors = 0;
  int fu_cnt;
  int fu_first;
  int bad;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .vs           (vs),
    .run          (run),
    .pongbar1_y   (pb1),
    .pongbar2_y   (pb2),
    .bal_x        (bal_x),
    .bal_y        (bal_y),
    .score1       (score1),
    .score2       (score2),
    .game_over    (game_over),
    .frame_update (frame_update)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: vs high for 4 cycles. Records how many cycles frame_update
  // was high and the first one, counted in cycles after the tick edge.
  task automatic do_tick(input bit drop_run);
    fu_cnt   = 0;
    fu_first = -1;
    @(negedge clk);
    vs = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1 && drop_run) run = 1'b0;
      if (c == 4) vs = 1'b0;
      if (frame_update === 1'b1) begin
        fu_cnt++;
        if (fu_first < 0) fu_first = c;
      end
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0);
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check_val({tag, "_x"}, 32'(bal_x), x);
    check_val({tag, "_y"}, 32'(bal_y), y);
  endtask

  initial begin
    reset = 1'b1;
    vs    = 1'b0;
    run   = 1'b0;
    pb1   = 16'd150;
    pb2   = 16'd400;

    // Reset state
    repeat (3) @(negedge clk);
    check_ball("rst", 316, 236);
    check_val("rst_s1", 32'(score1), 0);
    check_val("rst_s2", 32'(score2), 0);
    check_val("rst_go", 32'(game_over), 0);
    check_val("rst_fu", 32'(frame_update), 0);
    reset = 1'b0;

    // Paused in IDLE: ticks change nothing
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      do_tick(1'b0);
      bad += fu_cnt;
    end
    check_val("idle_fu", bad, 0);
    check_ball("idle", 316, 236);

    // Basic motion and latency (frame 1, 2)
    run = 1'b1;
    do_tick(1'b0);
    check_val("lat_fu_cnt", fu_cnt, 1);
    check_val("lat_fu_cyc", fu_first, 3);
    check_ball("k1", 320, 240);
    do_tick(1'b0);
    check_ball("k2", 324, 244);

    // Bottom wall at frame 59
    tick_n(56);
    check_ball("k58", 548, 468);
    do_tick(1'b0);
    check_ball("k59", 552, 472);
    do_tick(1'b0);
    check_ball("k60", 556, 468);

    // Right paddle bounce at frame 73 (ball y 416, paddle 400)
    tick_n(12);
    do_tick(1'b0);
    check_ball("k73", 608, 416);
    pb2 = 16'd180;
    do_tick(1'b0);
    check_ball("k74", 604, 412);

    // Left paddle bounce at frame 219 (ball y 168, paddle 150)
    tick_n(144);
    check_ball("k218", 28, 164);
    do_tick(1'b0);
    check_ball("k219", 24, 168);
    pb1 = 16'd300;
    do_tick(1'b0);
    check_ball("k220", 28, 172);

    // Right bounce at 365 (y 192, paddle 180); left miss at 511 (y 392,
    // paddle 300); ball reaches x=0 at frame 517
    tick_n(296);
    do_tick(1'b0);
    check_val("miss_l_s2", 32'(score2), 1);
    check_val("miss_l_s1", 32'(score1), 0);
    check_val("miss_l_fu", fu_first, 4);
    check_ball("miss_l", 316, 236);
    pb1 = 16'd400;
    pb2 = 16'd200;

    // Serve hold: 60 frames at centre with no updates, then serve left
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      do_tick(1'b0);
      if (bal_x !== 16'd316 || bal_y !== 16'd236 || fu_cnt != 0) bad++;
    end
    check_val("serve_hold", bad, 0);
    do_tick(1'b0);
    check_ball("serve_go", 312, 240);
    check_val("serve_go_fu", fu_first, 3);

    // Left bounce at j=73 (y 416, paddle 400), right miss at j=225
    tick_n(223);
    do_tick(1'b0);
    check_val("pt1_s1", 32'(score1), 1);
    check_val("pt1_fu", fu_first, 4);

    // Points 2..9: each serve heads right and misses paddle at 200
    for (int p = 2; p <= 9; p++) begin
      tick_n(60);
      tick_n(78);
      do_tick(p == 9);
      check_val($sformatf("pt%0d_s1", p), 32'(score1), p);
    end
    check_val("go_flag", 32'(game_over), 1);
    check_val("go_s2", 32'(score2), 1);
    check_val("go_fu", fu_cnt, 0);
    check_ball("go", 316, 236);
    repeat (3) @(negedge clk);
    check_val("go_hold_s1", 32'(score1), 9);

    // run 0->1 clears the finished game
    run = 1'b1;
    @(negedge clk);
    check_val("clr_s1", 32'(score1), 0);
    check_val("clr_s2", 32'(score2), 0);
    check_val("clr_go", 32'(game_over), 0);

    // Reset taken while in HIT
    @(negedge clk);
    @(negedge clk);
    vs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    vs    = 1'b0;
    @(negedge clk);
    check_ball("hit_rst", 316, 236);
    check_val("hit_rst_fu", 32'(frame_update), 0);
    check_val("hit_rst_s1", 32'(score1), 0);
    check_val("hit_rst_go", 32'(game_over), 0);
    reset = 1'b0;
    do_tick(1'b0);
    check_ball("post_rst", 320, 240);
    check_val("post_rst_fu", fu_first, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
